// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: redirect control, imem request/response, decode handshake
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            halted;

  modport master (
    input  redirect_en, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, halted
  );

  modport slave (
    output redirect_en, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with credit-limited prefetch, redirect flush and halt
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   out_q, disc_q, cnt_q;
  logic [PW-1:0]   tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;
  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic [31:0]     buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];

  logic credit, req_valid, issue, rsp, push, pop, head_valid, rsp_is_halt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    head_valid  = (cnt_q != '0);
    credit      = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH);
    req_valid   = (state_q == RUN) && credit && !bus.redirect_en;
    issue       = req_valid && bus.imem_req_ready;
    rsp         = bus.imem_rsp_valid;
    rsp_is_halt = (bus.imem_rsp_data[31:29] == 3'b000) && (bus.imem_rsp_data[26:24] == 3'b111);
    // stale responses owed to a redirect, or anything arriving after a halt, never reach decode
    push        = rsp && (disc_q == '0) && (state_q == RUN) && !bus.redirect_en;
    pop         = head_valid && bus.instr_ready && !bus.redirect_en;
    if (bus.redirect_en) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (push && rsp_is_halt) state_d = DRAIN;
        DRAIN:   if (pop && cnt_q == CW'(1)) state_d = HALT;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
    end else begin
      out_q <= out_q + CW'(issue) - CW'(rsp);
      if (issue) tag_wr_q <= next_ptr(tag_wr_q);
      if (rsp)   tag_rd_q <= next_ptr(tag_rd_q);
      if (bus.redirect_en) begin
        pc_q     <= bus.redirect_pc;
        disc_q   <= out_q - CW'(rsp);
        cnt_q    <= '0;
        buf_wr_q <= '0;
        buf_rd_q <= '0;
      end else begin
        if (issue) pc_q <= pc_q + XLEN'(PC_STEP);
        if (rsp && disc_q != '0) disc_q <= disc_q - CW'(1);
        if (push) buf_wr_q <= next_ptr(buf_wr_q);
        if (pop)  buf_rd_q <= next_ptr(buf_rd_q);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  // tag queue stays in step with outstanding requests, so it is never flushed
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      buf_data[buf_wr_q] <= bus.imem_rsp_data;
      buf_pc[buf_wr_q]   <= tag_mem[tag_rd_q];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = head_valid ? buf_data[buf_rd_q] : '0;
  assign bus.instr_pc       = head_valid ? buf_pc[buf_rd_q] : '0;
  assign bus.halted         = (state_q == HALT);
endmodule
